dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single-port data RAM between the CPU data port (M0) and a secondary requester (M1: DMA engine or debug loader). It sits between the core's data-memory port and `data_ram`, drives the RAM's ce/we/addr/data/sel, and returns read data to whichever master issued the access. It also produces a stall indication for the CPU when M0 is refused. M0 has fixed priority; M1 is protected by a starvation counter and may lock the RAM for short bursts.

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_arbiter_sat_counter.sv | 30 +++
 rtl/dmem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Default data bus width of the core.
    localparam int RegBus = 32;

    // Read-return owner encoding.
    localparam logic OwnerM0 = 1'b0;
    localparam logic OwnerM1 = 1'b1;

    // Arbiter lock state.
    typedef enum logic {
        ArbIdle    = 1'b0,
        ArbM1Burst = 1'b1
    } arb_state_e;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_counter #(
    parameter int MAX = 8,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;

    // Count up to MAX and hold there until cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {W{1'b0}};
        end else if (clr) begin
            count_r <= {W{1'b0}};
        end else if (inc && (count_r != W'(MAX))) begin
            count_r <= count_r + W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data RAM: CPU data port (M0) has
// fixed priority, the secondary requester (M1) is protected by a starvation
// counter and may lock the RAM for short bursts.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = RegBus,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic                m1_lock,
    output logic                m0_gnt,
    output logic                m1_gnt,
    output logic                m0_stall,
    output logic                m0_rvalid,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic [DATA_W/8-1:0] ram_sel,
    input  logic [DATA_W-1:0]   ram_rdata
);

    localparam int SelW  = DATA_W / 8;
    localparam int WaitW = cnt_width(MAX_WAIT);
    localparam int BeatW = cnt_width(BURST_MAX);

    arb_state_e       state_r;
    logic             m0_first_r;
    logic             m0_rvalid_r;
    logic             m1_rvalid_r;

    logic [WaitW-1:0] wait_cnt_s;
    logic [BeatW-1:0] beat_cnt_s;
    logic             m0_gnt_s;
    logic             m1_gnt_s;
    logic             enter_s;
    logic             burst_end_s;
    logic             max_exit_s;
    logic             beat_clr_s;
    logic             beat_inc_s;
    logic             wait_clr_s;
    logic             wait_inc_s;

    // Grant decision and burst bookkeeping from requests and registered state.
    always_comb begin
        m0_gnt_s    = 1'b0;
        m1_gnt_s    = 1'b0;
        enter_s     = 1'b0;
        burst_end_s = 1'b0;
        max_exit_s  = 1'b0;
        beat_clr_s  = 1'b1;
        beat_inc_s  = 1'b0;
        case (state_r)
            ArbIdle: begin
                // The cycle after a full-length burst M0 goes first.
                if (m0_first_r && m0_req) begin
                    m0_gnt_s = 1'b1;
                end else if ((wait_cnt_s == WaitW'(MAX_WAIT)) && m1_req) begin
                    m1_gnt_s = 1'b1;
                end else if (m0_req) begin
                    m0_gnt_s = 1'b1;
                end else if (m1_req) begin
                    m1_gnt_s = 1'b1;
                end else begin
                    m0_gnt_s = 1'b0;
                end
                // A locked M1 beat opens a burst and counts as beat one; with a
                // one-beat limit that first beat already exhausts the burst.
                if (m1_gnt_s && m1_lock) begin
                    if (BURST_MAX > 1) begin
                        enter_s    = 1'b1;
                        beat_clr_s = 1'b0;
                        beat_inc_s = 1'b1;
                    end else begin
                        max_exit_s = 1'b1;
                    end
                end else begin
                    enter_s = 1'b0;
                end
            end
            ArbM1Burst: begin
                m1_gnt_s = m1_req;
                if (!m1_req) begin
                    burst_end_s = 1'b1;
                end else if (beat_cnt_s == BeatW'(BURST_MAX - 1)) begin
                    burst_end_s = 1'b1;
                    max_exit_s  = 1'b1;
                end else if (!m1_lock) begin
                    burst_end_s = 1'b1;
                end else begin
                    beat_clr_s = 1'b0;
                    beat_inc_s = 1'b1;
                end
            end
            default: begin
                burst_end_s = 1'b1;
            end
        endcase
    end

    // Starvation counter control: count refused M1 cycles only.
    always_comb begin
        wait_clr_s = m1_gnt_s | ~m1_req;
        wait_inc_s = m1_req & ~m1_gnt_s;
    end

    arb_sat_counter #(
        .MAX (MAX_WAIT),
        .W   (WaitW)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (wait_clr_s),
        .inc   (wait_inc_s),
        .count (wait_cnt_s)
    );

    arb_sat_counter #(
        .MAX (BURST_MAX),
        .W   (BeatW)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (beat_clr_s),
        .inc   (beat_inc_s),
        .count (beat_cnt_s)
    );

    // RAM port mux: granted master's fields, all zero when nobody is granted.
    always_comb begin
        if (m1_gnt_s) begin
            ram_ce    = 1'b1;
            ram_we    = m1_we;
            ram_addr  = m1_addr;
            ram_wdata = m1_wdata;
            ram_sel   = m1_sel;
        end else if (m0_gnt_s) begin
            ram_ce    = 1'b1;
            ram_we    = m0_we;
            ram_addr  = m0_addr;
            ram_wdata = m0_wdata;
            ram_sel   = m0_sel;
        end else begin
            ram_ce    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = {ADDR_W{1'b0}};
            ram_wdata = {DATA_W{1'b0}};
            ram_sel   = {SelW{1'b0}};
        end
    end

    // Lock FSM, post-burst M0 priority flag and read-return owner tracking.
    // The per-master rvalid registers together encode pending flag and owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ArbIdle;
            m0_first_r  <= 1'b0;
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
        end else begin
            case (state_r)
                ArbIdle: begin
                    state_r <= enter_s ? ArbM1Burst : ArbIdle;
                end
                ArbM1Burst: begin
                    state_r <= burst_end_s ? ArbIdle : ArbM1Burst;
                end
                default: begin
                    state_r <= ArbIdle;
                end
            endcase
            m0_first_r  <= max_exit_s;
            m0_rvalid_r <= m0_gnt_s & ~m0_we;
            m1_rvalid_r <= m1_gnt_s & ~m1_we;
        end
    end

    assign m0_gnt    = m0_gnt_s;
    assign m1_gnt    = m1_gnt_s;
    assign m0_stall  = m0_req & ~m0_gnt_s;
    assign m0_rvalid = m0_rvalid_r;
    assign m1_rvalid = m1_rvalid_r;
    assign m0_rdata  = m0_rvalid_r ? ram_rdata : {DATA_W{1'b0}};
    assign m1_rdata  = m1_rvalid_r ? ram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a behavioural RAM, a reference model
// of the arbitration rules checked every cycle, and directed scenarios with
// literal expectations.
module tb_dmem_arbiter;

    localparam int MAX_WAIT  = 8;
    localparam int BURST_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_gnt, m1_gnt, m0_stall, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    int total_checks  = 0;
    int passed_checks = 0;

    dmem_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_WAIT  (MAX_WAIT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_sel    (m0_sel),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_sel    (m1_sel),
        .m1_lock   (m1_lock),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_stall  (m0_stall),
        .m0_rvalid (m0_rvalid),
        .m1_rvalid (m1_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_sel   (ram_sel),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural data RAM driven by the arbiter, one-cycle read latency.
    logic [31:0] ram_mem [64];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= init_word(i);
            ram_rdata <= 32'h0;
        end else if (ram_ce) begin
            if (ram_we) ram_mem[ram_addr[7:2]] <= merge(ram_mem[ram_addr[7:2]], ram_wdata, ram_sel);
            else        ram_rdata <= ram_mem[ram_addr[7:2]];
        end
    end

    // Reference model: arbitration history and the memory contents each master should see.
    logic [31:0] model_mem [64];
    int          refused, beats;
    bit          locked, m0_prio;
    bit          pv0, pv1;
    logic [31:0] pdata;

    always @(negedge clk) begin
        bit e_g0, e_g1, new_prio;
        if (rst) begin
            for (int i = 0; i < 64; i++) model_mem[i] = init_word(i);
            refused = 0; beats = 0; locked = 0; m0_prio = 0;
            pv0 = 0; pv1 = 0; pdata = 32'h0;
        end else begin
            e_g0 = 0; e_g1 = 0;
            if (locked)                               e_g1 = m1_req;
            else if (m0_prio && m0_req)               e_g0 = 1;
            else if (refused >= MAX_WAIT && m1_req)   e_g1 = 1;
            else if (m0_req)                          e_g0 = 1;
            else if (m1_req)                          e_g1 = 1;

            chk("m0_gnt",   m0_gnt,   e_g0);
            chk("m1_gnt",   m1_gnt,   e_g1);
            chk("m0_stall", m0_stall, m0_req & ~e_g0);
            chk("ram_ce",   ram_ce,   e_g0 | e_g1);
            chk("ram_we",   ram_we,   e_g1 ? m1_we : (e_g0 ? m0_we : 1'b0));
            chk("ram_addr", ram_addr, e_g1 ? m1_addr : (e_g0 ? m0_addr : 32'h0));
            chk("ram_wdata", ram_wdata, e_g1 ? m1_wdata : (e_g0 ? m0_wdata : 32'h0));
            chk("ram_sel",  ram_sel,  e_g1 ? m1_sel : (e_g0 ? m0_sel : 4'h0));
            chk("m0_rvalid", m0_rvalid, pv0);
            chk("m1_rvalid", m1_rvalid, pv1);
            chk("m0_rdata", m0_rdata, pv0 ? pdata : 32'h0);
            chk("m1_rdata", m1_rdata, pv1 ? pdata : 32'h0);

            pv0 = e_g0 & ~m0_we;
            pv1 = e_g1 & ~m1_we;
            if (pv0) pdata = model_mem[m0_addr[7:2]];
            if (pv1) pdata = model_mem[m1_addr[7:2]];
            if (e_g0 && m0_we) model_mem[m0_addr[7:2]] = merge(model_mem[m0_addr[7:2]], m0_wdata, m0_sel);
            if (e_g1 && m1_we) model_mem[m1_addr[7:2]] = merge(model_mem[m1_addr[7:2]], m1_wdata, m1_sel);

            new_prio = 0;
            if (locked) begin
                if (!m1_req) locked = 0;
                else begin
                    beats++;
                    if (beats >= BURST_MAX) begin locked = 0; new_prio = 1; end
                    else if (!m1_lock) locked = 0;
                end
            end else if (e_g1 && m1_lock) begin
                beats = 1;
                if (BURST_MAX <= 1) new_prio = 1; else locked = 1;
            end
            m0_prio = new_prio;
            if (e_g1 || !m1_req) refused = 0;
            else if (refused < MAX_WAIT) refused++;
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic [3:0] s0,
                         input logic r1, input logic w1, input logic [31:0] a1,
                         input logic [31:0] d1, input logic [3:0] s1, input logic l1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0; m0_sel = s0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1; m1_sel = s1; m1_lock = l1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq[$];
        int first_m1;
        int k;
        bit m1_seen, m0_on;
        logic [14:0] pat;

        // Reset, then idle outputs.
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 1'b0);
        chk("rst_ram_ce", ram_ce, 1'b0);
        chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
        step();

        // Single M0 read at 0x10.
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("rd_m0_gnt", m0_gnt, 1'b1);
        chk("rd_ram_addr", ram_addr, 32'h10);
        step();
        idle();
        @(negedge clk);
        chk("rd_m0_rvalid", m0_rvalid, 1'b1);
        chk("rd_m0_rdata", m0_rdata, 32'hA000_0004);
        step();

        // Both masters request every cycle: starvation guard.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b1, 1'b0, 32'h24, 32'h0, 4'hF, 1'b0);
            @(negedge clk);
            seq.push_back(m1_gnt ? 1 : (m0_gnt ? 0 : 2));
            step();
        end
        idle();
        step();
        first_m1 = -1;
        for (int i = 11; i >= 0; i--) if (seq[i] == 1) first_m1 = i;
        chk("fair_first_m1", 64'(first_m1), 64'd8);
        chk("fair_m0_resume", 64'(seq[9]), 64'd0);

        // Locked burst of 6 M1 writes against a requesting M0.
        seq.delete();
        k = 0; m1_seen = 0; m0_on = 1;
        for (int it = 0; it < 40 && k < 6; it++) begin
            drive(m0_on, 1'b0, 32'h30, 32'h0, 4'hF,
                  1'b1, 1'b1, 32'h40 + 32'(4 * k), 32'hB000_0000 + 32'(k), 4'hF, k < 5);
            @(negedge clk);
            if (m1_gnt) begin
                seq.push_back(1); k++; m1_seen = 1;
            end else if (m0_gnt) begin
                seq.push_back(0);
                if (m1_seen) m0_on = 0;
            end
            step();
        end
        idle();
        step();
        chk("burst_done", 64'(k), 64'd6);
        pat = 15'h0;
        for (int i = 0; i < 15 && i < seq.size(); i++) pat[14 - i] = seq[i][0];
        chk("burst_len", 64'(seq.size()), 64'd15);
        chk("burst_order", pat, 15'b000000001111011);

        // Read back the burst data through M0.
        for (int j = 0; j < 7; j++) begin
            if (j < 6) drive(1'b1, 1'b0, 32'h40 + 32'(4 * j), 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            else       idle();
            @(negedge clk);
            if (j == 1) chk("burst_rb0", m0_rdata, 32'hB000_0000);
            if (j == 6) chk("burst_rb5", m0_rdata, 32'hB000_0005);
            step();
        end

        // Alternating reads M0@0x0 and M1@0x4.
        for (int j = 0; j < 7; j++) begin
            if (j == 6)          idle();
            else if (j % 2 == 0) drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
            else                 drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
            @(negedge clk);
            if (j > 0 && j % 2 == 1) begin
                chk("alt_m0_rdata", m0_rdata, 32'hA000_0000);
                chk("alt_m1_quiet", m1_rvalid, 1'b0);
            end else if (j > 0) begin
                chk("alt_m1_rdata", m1_rdata, 32'hA000_0001);
                chk("alt_m0_quiet", m0_rvalid, 1'b0);
            end
            step();
        end

        // Reset while an M1 locked read is pending.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1);
        @(negedge clk);
        chk("lock_gnt", m1_gnt, 1'b1);
        #1 rst = 1'b1;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_no_m1_rvalid", m1_rvalid, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        chk("rst_idle_m0_wins", {m0_gnt, m1_gnt}, 2'b10);
        step();
        idle();
        step();
        step();

        // M0 partial write, then read it back.
        drive(1'b1, 1'b1, 32'hC, 32'h1234_5678, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("wr_ram_we", ram_we, 1'b1);
        chk("wr_ram_sel", ram_sel, 4'b0011);
        chk("wr_no_stall", m0_stall, 1'b0);
        step();
        drive(1'b1, 1'b0, 32'hC, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        chk("wr_no_rvalid", m0_rvalid, 1'b0);
        step();
        idle();
        @(negedge clk);
        chk("wr_readback", m0_rdata, 32'hA000_5678);
        step();
        step();

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
